// File: rtl/key_click_decoder.sv
// Groups debounced key presses into bursts and reports the burst size as a one-cycle event.
// Optional KEY_CLICK_STAT_EN adds a free-running 16-bit count of all accepted presses.
module key_click_decoder #(
  parameter logic [23:0] GAP_MAX    = 24'd12_499_999,
  parameter logic [2:0]  MAX_CLICKS = 3'd3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        key_flag,
  output logic        click_valid,
  output logic [2:0]  click_num,
  output logic        busy
`ifdef KEY_CLICK_STAT_EN
  ,
  output logic [15:0] total_clicks
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [23:0] r_gap_cnt;
  logic [23:0] w_gap_cnt_next;
  logic [2:0]  r_click_acc;
  logic [2:0]  w_click_acc_next;
  logic        r_click_valid;
  logic        w_click_valid_next;
  logic [2:0]  r_click_num;
  logic [2:0]  w_click_num_next;
  logic [3:0]  w_acc_inc;

  // Widened so the comparison against MAX_CLICKS cannot wrap.
  assign w_acc_inc = {1'b0, r_click_acc} + 4'd1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state       <= IDLE;
      r_gap_cnt     <= '0;
      r_click_acc   <= '0;
      r_click_valid <= 1'b0;
      r_click_num   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_gap_cnt     <= w_gap_cnt_next;
      r_click_acc   <= w_click_acc_next;
      r_click_valid <= w_click_valid_next;
      r_click_num   <= w_click_num_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_gap_cnt_next     = r_gap_cnt;
    w_click_acc_next   = r_click_acc;
    w_click_valid_next = 1'b0;
    w_click_num_next   = r_click_num;
    case (r_state)
      IDLE: begin
        if (key_flag) begin
          if (MAX_CLICKS == 3'd1) begin
            w_click_valid_next = 1'b1;
            w_click_num_next   = 3'd1;
          end else begin
            w_click_acc_next = 3'd1;
            w_gap_cnt_next   = '0;
            w_state_next     = WAIT;
          end
        end
      end
      WAIT: begin
        // A press always takes priority over an expiring gap window.
        if (key_flag) begin
          if (w_acc_inc < {1'b0, MAX_CLICKS}) begin
            w_click_acc_next = w_acc_inc[2:0];
            w_gap_cnt_next   = '0;
          end else begin
            w_click_valid_next = 1'b1;
            w_click_num_next   = MAX_CLICKS;
            w_click_acc_next   = '0;
            w_gap_cnt_next     = '0;
            w_state_next       = IDLE;
          end
        end else if (r_gap_cnt < GAP_MAX) begin
          w_gap_cnt_next = r_gap_cnt + 24'd1;
        end else begin
          w_click_valid_next = 1'b1;
          w_click_num_next   = r_click_acc;
          w_click_acc_next   = '0;
          w_gap_cnt_next     = '0;
          w_state_next       = IDLE;
        end
      end
      default: begin
        w_state_next     = IDLE;
        w_gap_cnt_next   = '0;
        w_click_acc_next = '0;
      end
    endcase
  end

  assign click_valid = r_click_valid;
  assign click_num   = r_click_num;
  assign busy        = (r_state == WAIT);

`ifdef KEY_CLICK_STAT_EN
  logic [15:0] r_total_clicks;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_total_clicks <= '0;
    end else if (key_flag) begin
      r_total_clicks <= r_total_clicks + 16'd1;
    end
  end

  assign total_clicks = r_total_clicks;
`endif

endmodule

// File: tb/tb_key_click_decoder.sv
// Self-checking bench for key_click_decoder: vector table, directed corner sequences,
// and randomized presses checked against a timestamp-based burst model.
module tb_key_click_decoder;

  localparam logic [23:0] GAP   = 24'd10;
  localparam logic [2:0]  MAXC  = 3'd3;
  localparam int          GAP_I = 10;
  localparam int          MAX_I = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        key_flag;
  logic        click_valid;
  logic [2:0]  click_num;
  logic        busy;
`ifdef KEY_CLICK_STAT_EN
  logic [15:0] total_clicks;
`endif

  key_click_decoder #(
    .GAP_MAX    (GAP),
    .MAX_CLICKS (MAXC)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_flag    (key_flag),
    .click_valid (click_valid),
    .click_num   (click_num),
    .busy        (busy)
`ifdef KEY_CLICK_STAT_EN
    ,
    .total_clicks(total_clicks)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bursts tracked by press timestamps rather than a gap counter.
  int          m_cyc  = 0;
  bit          m_open = 1'b0;
  int          m_cnt  = 0;
  int          m_last = 0;
  bit          m_valid = 1'b0;
  logic [2:0]  m_num  = 3'd0;
  logic [15:0] m_tot  = 16'd0;

  task automatic model_update(input bit rst, input bit key);
    if (rst) begin
      m_open = 1'b0; m_cnt = 0; m_valid = 1'b0; m_num = 3'd0; m_tot = 16'd0;
    end else begin
      m_cyc++;
      m_valid = 1'b0;
      if (key) m_tot = m_tot + 16'd1;
      if (m_open) begin
        if (key) begin
          m_cnt++;
          m_last = m_cyc;
          if (m_cnt == MAX_I) begin
            m_valid = 1'b1; m_num = 3'(m_cnt); m_open = 1'b0;
          end
        end else if (m_cyc - m_last == GAP_I + 1) begin
          m_valid = 1'b1; m_num = 3'(m_cnt); m_open = 1'b0;
        end
      end else if (key) begin
        if (MAX_I == 1) begin
          m_valid = 1'b1; m_num = 3'd1;
        end else begin
          m_open = 1'b1; m_cnt = 1; m_last = m_cyc;
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit key);
    sys_rst  = rst;
    key_flag = key;
    @(posedge sys_clk);
    #1;
    model_update(rst, key);
  endtask

  task automatic cmp(input string nm, input bit v, input logic [2:0] n, input bit b);
    n_vec++;
    if (click_valid !== v || click_num !== n || busy !== b) begin
      n_err++;
      $display("FAIL %s: got valid=%0b num=%0d busy=%0b, need valid=%0b num=%0d busy=%0b",
               nm, click_valid, click_num, busy, v, n, b);
    end
  endtask

  task automatic tick(input bit rst, input bit key);
    step(rst, key);
    cmp("model", m_valid, m_num, m_open);
  endtask

  typedef struct {
    bit         rst;
    bit         key;
    bit         valid;
    logic [2:0] num;
    bit         busy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    sys_rst  = 1'b1;
    key_flag = 1'b0;

    // Reset with key pulsing, release, single press, timeout 11 edges later.
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 1'b1});
    for (int i = 0; i < 10; i++) tbl.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 3'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 3'd1, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].key);
      cmp($sformatf("table[%0d]", i), tbl[i].valid, tbl[i].num, tbl[i].busy);
    end
    $display("txn: single click table done");

    // Two presses 5 cycles apart: one report of 2, 11 edges after second press.
    tick(0, 1);
    repeat (4) tick(0, 0);
    tick(0, 1);
    repeat (10) tick(0, 0);
    tick(0, 0);
    cmp("double_report", 1'b1, 3'd2, 1'b0);
    repeat (3) tick(0, 0);
    $display("txn: double click done");

    // Three presses 3 cycles apart: immediate report on the third press edge.
    tick(0, 1);
    repeat (2) tick(0, 0);
    tick(0, 1);
    repeat (2) tick(0, 0);
    tick(0, 1);
    cmp("triple_immediate", 1'b1, 3'd3, 1'b0);
    repeat (15) tick(0, 0);
    $display("txn: triple click done");

    // Press arriving exactly when the gap window expires wins over the timeout.
    tick(0, 1);
    repeat (10) tick(0, 0);
    tick(0, 1);
    cmp("gap_edge_press", 1'b0, 3'd3, 1'b1);
    repeat (10) tick(0, 0);
    tick(0, 0);
    cmp("gap_edge_report", 1'b1, 3'd2, 1'b0);
    tick(0, 0);
    $display("txn: gap boundary press done");

    // Reset mid-burst discards it; the next press starts a fresh burst.
    tick(0, 1);
    repeat (3) tick(0, 0);
    tick(1, 0);
    cmp("rst_mid_burst", 1'b0, 3'd0, 1'b0);
    repeat (15) tick(0, 0);
    tick(0, 1);
    repeat (10) tick(0, 0);
    tick(0, 0);
    cmp("after_rst_single", 1'b1, 3'd1, 1'b0);
    $display("txn: reset mid burst done");

    // Key in the same cycle click_valid is high starts a new burst.
    tick(0, 1); tick(0, 1); tick(0, 1);
    tick(0, 1);
    cmp("press_on_valid", 1'b0, 3'd3, 1'b1);
    repeat (12) tick(0, 0);
    $display("txn: press on report cycle done");

    // Randomized traffic with alternating dense/sparse phases and rare resets.
    for (int i = 0; i < 3000; i++) begin
      bit rst_r, key_r;
      rst_r = ($urandom_range(0, 299) == 0);
      if (((i / 150) % 2) == 0) key_r = ($urandom_range(0, 2) == 0);
      else                      key_r = ($urandom_range(0, 13) == 0);
      tick(rst_r, key_r);
    end
    $display("txn: random phase done");

`ifdef KEY_CLICK_STAT_EN
    tick(1, 0);
    repeat (5) begin
      tick(0, 1);
      tick(0, 0);
    end
    n_vec++;
    if (total_clicks !== 16'd5) begin
      n_err++;
      $display("FAIL total_5: got %0d, need 5", total_clicks);
    end
    for (int i = 0; i < 65530; i++) step(0, 1);
    n_vec++;
    if (total_clicks !== m_tot || m_tot !== 16'hFFFF) begin
      n_err++;
      $display("FAIL total_ffff: got %h, need %h", total_clicks, m_tot);
    end
    tick(0, 1);
    n_vec++;
    if (total_clicks !== 16'd0) begin
      n_err++;
      $display("FAIL total_wrap: got %h, need 0000", total_clicks);
    end
    $display("txn: stat counter done");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
